// File: rtl/upc_tx_pkg.sv
// Shared types and constants for the UPC tag serial transmitter.
// UPC_TX_PARITY_EN selects the 7-bit frame with an even-parity bit; default is 6 bits.
package upc_tx_pkg;

  localparam int DATA_BITS = 4;

`ifdef UPC_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/upc_bit_timer.sv
// Bit-period timer: bit_end pulses on the last clock of every CLKS_PER_BIT window.
// 'clear' parks the counter at zero so a new frame starts on a fresh period.
module upc_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) cnt_d = '0;
  end

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/upc_tag_tx.sv
// Framed one-wire transmitter for {upc, mark}: start bit, U P C mark (MSB first),
// optional even parity when UPC_TX_PARITY_EN is defined, then a stop bit.
module upc_tag_tx
  import upc_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] upc,
  input  logic       mark,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       tx,
  output logic       done
);

  tx_state_t   state_q, state_d;
  logic [3:0]  sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        bit_end;

  upc_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_IDLE),
    .bit_end (bit_end)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = {upc, mark};
          idx_d   = 2'd0;
          state_d = ST_START;
        end
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          // Rotate rather than shift: after four bits the original word is back in place.
          sr_d  = {sr_q[2:0], sr_q[3]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef UPC_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UPC_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    tx = LINE_IDLE;
    case (state_q)
      ST_START:  tx = START_LVL;
      ST_DATA:   tx = sr_q[3];
      ST_PARITY: tx = ^sr_q;
      default:   tx = LINE_IDLE;
    endcase
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = ~ready;
  assign done  = done_q;

endmodule
